sensor_pattern_gen: RTL

- Parametrised image-sensor emulator for DAQ bring-up and bench testing.
- Drives a parallel pixel bus (data_out, pclk_out, frame_valid, line_valid) with the same timing shape as the Miniscope sensor front end.
- Generalises the fixed 8-bit incrementing generator: configurable data width, frame geometry, blanking, pixel-clock divider and run-time pattern mode.
- Sits in place of the sensor, upstream of the capture/Wi-Fi packetiser.

---
 rtl/sensor_pattern_gen.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sensor_pattern_gen.sv
// sensor_pattern_gen: parametrised image-sensor emulator.
// Drives a parallel pixel bus (data_out, pclk_out, frame_valid, line_valid)
// with the same timing shape as the sensor front end. Frame geometry,
// blanking, pixel-clock divider, data width and test pattern are configurable.
// Optional feature: define SENSOR_PATTERN_PRBS_EN to turn pattern mode 3 into
// a PRBS-15 (x^15 + x^14 + 1) generator. If it is not defined, mode 3 is the
// row index.
module sensor_pattern_gen #(
  parameter int DATA_W       = 8,
  parameter int PCLK_DIV_MAX = 24,
  parameter int H_ACTIVE     = 608,
  parameter int H_BLANK      = 20,
  parameter int V_ACTIVE     = 608,
  parameter int V_BLANK      = 200,
  parameter int FV_PORCH     = 4
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] const_val,
  output logic [DATA_W-1:0] data_out,
  output logic              pclk_out,
  output logic              frame_valid,
  output logic              line_valid,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam int DIV_W     = (PCLK_DIV_MAX < 1) ? 1 : $clog2(PCLK_DIV_MAX + 1);
  localparam int X_W       = (H_ACTIVE < 2) ? 1 : $clog2(H_ACTIVE);
  localparam int Y_W       = (V_ACTIVE < 2) ? 1 : $clog2(V_ACTIVE);
  localparam int BLANK_MAX = (H_BLANK > V_BLANK) ?
                             ((H_BLANK > FV_PORCH) ? H_BLANK : FV_PORCH) :
                             ((V_BLANK > FV_PORCH) ? V_BLANK : FV_PORCH);
  localparam int B_W       = (BLANK_MAX < 2) ? 1 : $clog2(BLANK_MAX);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(PCLK_DIV_MAX);
  localparam logic [X_W-1:0]   X_LAST     = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]   Y_LAST     = Y_W'(V_ACTIVE - 1);
  localparam logic [B_W-1:0]   HB_LAST    = B_W'(H_BLANK - 1);
  localparam logic [B_W-1:0]   VB_LAST    = B_W'(V_BLANK - 1);
  localparam logic [B_W-1:0]   PORCH_LAST = B_W'(FV_PORCH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FV_LEAD,
    ST_ACTIVE,
    ST_HBLANK,
    ST_FV_TAIL,
    ST_VBLANK
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_div;
  logic               tick;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [B_W-1:0]     blank_q, blank_d;
  logic [DATA_W-1:0]  pix_q, pix_d;
  logic [1:0]         mode_q, mode_d;
  logic [DATA_W-1:0]  const_q, const_d;
  logic [DATA_W-1:0]  data_d;
  logic               lv_d, fv_d;
  logic [15:0]        fcnt_d;
  logic               start_frame;
  logic [DATA_W-1:0]  checker_val;
  logic [DATA_W-1:0]  pattern_val;

`ifdef SENSOR_PATTERN_PRBS_EN
  logic [14:0]        lfsr_q, lfsr_d;
  logic [DATA_W-1:0]  prbs_val;

  // PRBS output is the low bits of the LFSR, zero-extended on wide buses
  if (DATA_W > 15) begin : g_prbs_ext
    assign prbs_val = {{(DATA_W-15){1'b0}}, lfsr_q};
  end else begin : g_prbs_trunc
    assign prbs_val = lfsr_q[DATA_W-1:0];
  end
`else
  logic [DATA_W-1:0]  row_val;

  // Row index pattern is y modulo 2^DATA_W
  if (Y_W >= DATA_W) begin : g_row_trunc
    assign row_val = y_q[DATA_W-1:0];
  end else begin : g_row_ext
    assign row_val = {{(DATA_W-Y_W){1'b0}}, y_q};
  end
`endif

  assign busy = (state_q != ST_IDLE);

  // A pixel tick is the sys_clk cycle in which pclk_out falls
  assign tick = busy && pclk_out && (cnt_div == DIV_LAST);

  // The first pixel of each frame (x=0, y=0) is all-ones; squares alternate
  assign checker_val = {DATA_W{~(x_q[0] ^ y_q[0])}};

  // Pixel clock divider, held at zero whenever the generator is idle
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_div  <= '0;
      pclk_out <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      cnt_div  <= '0;
      pclk_out <= 1'b0;
    end else if (cnt_div == DIV_LAST) begin
      cnt_div  <= '0;
      pclk_out <= ~pclk_out;
    end else begin
      cnt_div  <= cnt_div + 1'b1;
    end
  end

  // Select the value for the current active pixel from the latched mode
  always_comb begin
    pattern_val = '0;
    case (mode_q)
      2'd0:    pattern_val = pix_q;
      2'd1:    pattern_val = const_q;
      2'd2:    pattern_val = checker_val;
`ifdef SENSOR_PATTERN_PRBS_EN
      default: pattern_val = prbs_val;
`else
      default: pattern_val = row_val;
`endif
    endcase
  end

  // Frame sequencer: next state, pixel counters and bus values per tick
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    blank_d     = blank_q;
    pix_d       = pix_q;
    mode_d      = mode_q;
    const_d     = const_q;
    data_d      = data_out;
    lv_d        = line_valid;
    fv_d        = frame_valid;
    fcnt_d      = frame_cnt;
    start_frame = 1'b0;
`ifdef SENSOR_PATTERN_PRBS_EN
    lfsr_d      = lfsr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d     = ST_FV_LEAD;
          start_frame = 1'b1;
        end
      end

      ST_FV_LEAD: begin
        if (tick) begin
          fv_d   = 1'b1;
          lv_d   = 1'b0;
          data_d = '0;
          if (blank_q == PORCH_LAST) begin
            blank_d = '0;
            state_d = ST_ACTIVE;
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end
      end

      ST_ACTIVE: begin
        if (tick) begin
          fv_d   = 1'b1;
          lv_d   = 1'b1;
          data_d = pattern_val;
          pix_d  = pix_q + 1'b1;
`ifdef SENSOR_PATTERN_PRBS_EN
          lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
`endif
          if (x_q == X_LAST) begin
            x_d     = '0;
            blank_d = '0;
            if (y_q == Y_LAST) begin
              state_d = ST_FV_TAIL;
            end else begin
              y_d     = y_q + 1'b1;
              state_d = ST_HBLANK;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end

      ST_HBLANK: begin
        if (tick) begin
          lv_d   = 1'b0;
          data_d = '0;
          if (blank_q == HB_LAST) begin
            blank_d = '0;
            state_d = ST_ACTIVE;
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end
      end

      ST_FV_TAIL: begin
        if (tick) begin
          fv_d   = 1'b1;
          lv_d   = 1'b0;
          data_d = '0;
          if (blank_q == PORCH_LAST) begin
            blank_d = '0;
            state_d = ST_VBLANK;
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end
      end

      ST_VBLANK: begin
        if (tick) begin
          fv_d   = 1'b0;
          lv_d   = 1'b0;
          data_d = '0;
          if (frame_valid) begin
            fcnt_d = frame_cnt + 16'd1;
          end
          if (blank_q == VB_LAST) begin
            blank_d = '0;
            if (enable) begin
              state_d     = ST_FV_LEAD;
              start_frame = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_frame) begin
      mode_d  = mode;
      const_d = const_val;
      x_d     = '0;
      y_d     = '0;
      pix_d   = '0;
      blank_d = '0;
`ifdef SENSOR_PATTERN_PRBS_EN
      lfsr_d  = 15'h0001;
`endif
    end
  end

  // State and bus registers; reset aborts any frame in progress
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      blank_q     <= '0;
      pix_q       <= '0;
      mode_q      <= '0;
      const_q     <= '0;
      data_out    <= '0;
      line_valid  <= 1'b0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      blank_q     <= blank_d;
      pix_q       <= pix_d;
      mode_q      <= mode_d;
      const_q     <= const_d;
      data_out    <= data_d;
      line_valid  <= lv_d;
      frame_valid <= fv_d;
      frame_cnt   <= fcnt_d;
    end
  end

`ifdef SENSOR_PATTERN_PRBS_EN
  // PRBS-15 state, reseeded at every frame start
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 15'h0001;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

endmodule
